mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin packet arbiter that shares one output stream among NUM_INPUTS requesting streams.
- Each requester presents a valid/ready/last stream.
- Block owns the select of the existing `mux` block, which it instantiates internally for the data path.
- Holds a grant for a whole packet, up to and including the beat marked last, then rotates priority.

Parameters:
- NUM_INPUTS, 8: number of requesters; must be ≥ 2.
- WIDTH_INPUTS, 4: data width per requester.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  [NUM_INPUTS-1:0][WIDTH_INPUTS-1:0]  requester data, packed as for `mux`.
- in_valid  input  NUM_INPUTS  per-requester beat valid.
- in_last  input  NUM_INPUTS  per-requester last beat of packet.
- in_ready  output  NUM_INPUTS  per-requester beat accepted when valid & ready.
- req_mask  input  NUM_INPUTS  1 = requester eligible for new grants (configuration).
- out_data  output  WIDTH_INPUTS  selected data.
- out_valid  output  1  output beat valid.
- out_last  output  1  output last.
- out_ready  input  1  downstream ready.
- sel  output  $clog2(NUM_INPUTS)  current mux select (registered).
- busy  output  1  1 while a grant is held.

Behaviour:
- Reset (async assert): state IDLE, sel=0, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=in_data[0] (combinational through mux), priority pointer last_grant=NUM_INPUTS-1 (input 0 highest priority first).
- States: IDLE, LOCKED.
- IDLE:
  - Eligible set E = in_valid & req_mask.
  - If E != 0: pick first set bit of E searching (last_grant+1) upward with wrap mod NUM_INPUTS. Register sel=winner, last_grant=winner, busy=1, go LOCKED.
  - If E = 0: stay IDLE.
  - in_ready all 0 and out_valid=0 in IDLE.
- LOCKED, combinational:
  - out_valid=in_valid[sel]; out_last=in_last[sel]; out_data=in_data[sel] via `mux`.
  - in_ready[sel]=out_ready; every other in_ready bit 0.
- LOCKED, transitions:
  - Handshake (out_valid & out_ready) with out_last=1: go IDLE, busy=0 next cycle; sel holds its value.
  - Otherwise stay LOCKED.
  - in_valid[sel] dropping mid-packet does not release the grant; the block waits.
- Latency: first request to grant is 1 cycle (request seen in IDLE at edge N, data passes from cycle N+1). Release costs one IDLE bubble cycle between packets.
- Fairness: a requester with a continuously pending packet waits at most NUM_INPUTS-1 packets.
- req_mask: sampled only in IDLE. Clearing a bit while that requester is LOCKED does not abort its packet.
- Single-beat packet (last on first beat): LOCKED for 1 cycle if out_ready=1.
- Reset mid-packet: grant dropped immediately, outputs return to reset values, pointer returns to NUM_INPUTS-1; partial packet is not completed.
- sel width: $clog2(NUM_INPUTS). Non-power-of-2 NUM_INPUTS: sel never exceeds NUM_INPUTS-1.

Test Plan:
- Reset then in_valid=8'h01, req_mask=8'hFF, in_data[0]=4'h5, in_last[0]=1, out_ready=1 -> cycle after request: sel=0, busy=1, out_valid=1, out_data=5, in_ready=8'h01; next cycle busy=0, in_ready=0.
- All 8 requesters valid with single-beat packets, in_data[i]=i, out_ready=1 -> grants in order 0,1,...,7,0, each separated by one IDLE cycle; out_data matches sel every beat.
- Requester 2 sends 3-beat packet (last on beat 3) while requester 5 is valid -> sel stays 2 for all 3 beats; requester 5 granted only after beat 3 handshake; in_ready[5]=0 throughout.
- Backpressure: out_ready=0 for 4 cycles during LOCKED on input 3 -> out_valid=1, in_ready=0, sel=3 held, no release until out_ready=1 with last.
- req_mask=8'hFB with requesters 2 and 6 valid, last_grant=1 -> requester 6 granted, 2 never granted while masked; mask cleared mid-packet of 6 does not abort it.
- Assert rst_n=0 mid-packet on input 4 -> busy, out_valid, in_ready go 0 immediately (no clock); after release, next grant to lowest valid index starting at 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: grants one requester for a whole packet and
// steers its stream through the shared data mux.

module mux #(
  parameter int NUM_INPUTS   = 8,
  parameter int WIDTH_INPUTS = 4
) (
  input  logic [NUM_INPUTS-1:0][WIDTH_INPUTS-1:0] in_data,
  input  logic [$clog2(NUM_INPUTS)-1:0]           sel,
  output logic [WIDTH_INPUTS-1:0]                 out_data
);
  assign out_data = in_data[sel];
endmodule

module mux_rr_arbiter #(
  parameter int NUM_INPUTS   = 8,
  parameter int WIDTH_INPUTS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_INPUTS-1:0][WIDTH_INPUTS-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]                   in_valid,
  input  logic [NUM_INPUTS-1:0]                   in_last,
  output logic [NUM_INPUTS-1:0]                   in_ready,
  input  logic [NUM_INPUTS-1:0]                   req_mask,
  output logic [WIDTH_INPUTS-1:0]                 out_data,
  output logic                                    out_valid,
  output logic                                    out_last,
  input  logic                                    out_ready,
  output logic [$clog2(NUM_INPUTS)-1:0]           sel,
  output logic                                    busy
);
  localparam int SEL_W = $clog2(NUM_INPUTS);
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic             r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last_grant;

  logic                  w_locked;
  logic                  w_release;
  logic [NUM_INPUTS-1:0] w_elig;
  logic [NUM_INPUTS-1:0] w_upper;
  logic [SEL_W-1:0]      w_up_idx;
  logic [SEL_W-1:0]      w_any_idx;
  logic [SEL_W-1:0]      w_winner;

  assign w_locked = (r_state == ST_LOCKED);
  assign w_elig   = in_valid & req_mask;

  // w_upper holds eligible requesters above the pointer; if none, wrap to the lowest eligible.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_req
      assign w_upper[gi]  = w_elig[gi] && (SEL_W'(gi) > r_last_grant);
      assign in_ready[gi] = w_locked && out_ready && (r_sel == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_up_idx  = '0;
    w_any_idx = '0;
    for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
      if (w_upper[j]) w_up_idx  = SEL_W'(j);
      if (w_elig[j])  w_any_idx = SEL_W'(j);
    end
    w_winner = (|w_upper) ? w_up_idx : w_any_idx;
  end

  mux #(
    .NUM_INPUTS   (NUM_INPUTS),
    .WIDTH_INPUTS (WIDTH_INPUTS)
  ) u_mux (
    .in_data  (in_data),
    .sel      (r_sel),
    .out_data (out_data)
  );

  assign out_valid = w_locked && in_valid[r_sel];
  assign out_last  = w_locked && in_last[r_sel];
  assign w_release = out_valid && out_ready && out_last;
  assign sel       = r_sel;
  assign busy      = w_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_last_grant <= SEL_W'(NUM_INPUTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_sel        <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ST_LOCKED;
          end
        end
        default: begin
          if (w_release) r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
